ctmm_msave: RTL



---
 rtl/ctmm_pkg.sv | 52 +++++
 rtl/ctmm_msave.sv | 138 +++++++++++++
 2 files changed

// File: rtl/ctmm_pkg.sv
// Shared CLOOMC types: capability register layout, fault codes and the mSave
// routine's states, plus the C-List slot check used when saving a GT.
package ctmm_pkg;

    localparam int GT_PERM_S_BIT     = 1;
    localparam int CLIST_ENTRY_BYTES = 8;

    typedef struct packed {
        logic [63:0] gt;
        logic [63:0] base;
        logic [63:0] limit;
    } capability_reg_t;

    typedef enum logic [2:0] {
        FAULT_NONE          = 3'd0,
        FAULT_CLIST_INVALID = 3'd1,
        FAULT_NO_SAVE_PERM  = 3'd2,
        FAULT_CLIST_BOUNDS  = 3'd3,
        FAULT_MEM_TIMEOUT   = 3'd4
    } fault_type_t;

    typedef enum logic [2:0] {
        MS_IDLE,
        MS_RD_CLIST,
        MS_CHECK,
        MS_RD_SRC,
        MS_WRITE,
        MS_DONE,
        MS_FAULT
    } msave_state_t;

    // Offset and address arithmetic is 65 bits wide so neither can wrap silently.
    function automatic fault_type_t msave_check(input capability_reg_t c, input logic [7:0] index);
        logic [64:0] off;
        logic [64:0] end_off;
        logic [64:0] sum;
        off     = {54'b0, index, 3'b000};
        end_off = off + 65'(CLIST_ENTRY_BYTES);
        sum     = {1'b0, c.base} + off;
        if (c.gt == 64'b0)
            return FAULT_CLIST_INVALID;
        else if (!c.gt[GT_PERM_S_BIT])
            return FAULT_NO_SAVE_PERM;
        else if (end_off > {1'b0, c.limit})
            return FAULT_CLIST_BOUNDS;
        else if (sum[64])
            return FAULT_CLIST_BOUNDS;
        else
            return FAULT_NONE;
    endfunction

endpackage

// File: rtl/ctmm_msave.sv
// mSave micro-routine: stores the GT of a source CR into a C-List slot named
// by a destination CR, behind the sub_start/sub_busy/sub_done handshake.
//
// state     | meaning
// IDLE      | waiting for an armed sub_start
// RD_CLIST  | reading the C-List CR (address cycle, then data cycle)
// CHECK     | acting on the C-List validity/permission/bounds verdict
// RD_SRC    | source CR data arriving; loads the write data
// WRITE     | mem_wr_en held until ack or timeout
// DONE      | success pulse with g_bit_set
// FAULT     | fault pulse, no write performed
module ctmm_msave
    import ctmm_pkg::*;
#(
    parameter int MEM_TIMEOUT = 256
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sub_start,
    input  logic [3:0]      sub_cr_src,
    input  logic [3:0]      sub_cr_dst,
    input  logic [7:0]      sub_index,
    output logic            sub_busy,
    output logic            sub_done,
    output logic            sub_fault,
    output fault_type_t     sub_fault_type,
    output logic [3:0]      cr_rd_addr,
    input  capability_reg_t cr_rd_data,
    output logic [63:0]     mem_addr,
    output logic            mem_wr_en,
    output logic [63:0]     mem_wr_data,
    input  logic            mem_wr_ack,
    output logic            g_bit_set,
    output logic [63:0]     g_bit_addr
);

    localparam int TW = $clog2(MEM_TIMEOUT);

    msave_state_t state;
    logic         armed;
    logic         rd_phase;
    logic [3:0]   src_q;
    logic [7:0]   idx_q;
    fault_type_t  chk_fault;
    logic [63:0]  chk_addr;
    logic [TW-1:0] tmo_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= MS_IDLE;
            armed          <= 1'b1;
            rd_phase       <= 1'b0;
            src_q          <= '0;
            idx_q          <= '0;
            chk_fault      <= FAULT_NONE;
            chk_addr       <= '0;
            tmo_cnt        <= '0;
            sub_busy       <= 1'b0;
            sub_done       <= 1'b0;
            sub_fault      <= 1'b0;
            sub_fault_type <= FAULT_NONE;
            cr_rd_addr     <= '0;
            mem_addr       <= '0;
            mem_wr_en      <= 1'b0;
            mem_wr_data    <= '0;
            g_bit_set      <= 1'b0;
            g_bit_addr     <= '0;
        end else begin
            sub_done  <= 1'b0;
            sub_fault <= 1'b0;
            g_bit_set <= 1'b0;
            case (state)
                MS_IDLE: begin
                    if (!sub_start) begin
                        armed <= 1'b1;
                    end else if (armed) begin
                        armed      <= 1'b0;
                        src_q      <= sub_cr_src;
                        idx_q      <= sub_index;
                        cr_rd_addr <= sub_cr_dst;
                        rd_phase   <= 1'b0;
                        sub_busy   <= 1'b1;
                        state      <= MS_RD_CLIST;
                    end
                end
                // Second RD_CLIST cycle holds the C-List data; judge it here and
                // switch the read port to src so its data lands in RD_SRC.
                MS_RD_CLIST: begin
                    rd_phase <= 1'b1;
                    if (rd_phase) begin
                        chk_fault  <= msave_check(cr_rd_data, idx_q);
                        chk_addr   <= cr_rd_data.base + {53'b0, idx_q, 3'b000};
                        cr_rd_addr <= src_q;
                        state      <= MS_CHECK;
                    end
                end
                MS_CHECK: begin
                    if (chk_fault != FAULT_NONE) begin
                        sub_fault      <= 1'b1;
                        sub_fault_type <= chk_fault;
                        state          <= MS_FAULT;
                    end else begin
                        mem_addr <= chk_addr;
                        state    <= MS_RD_SRC;
                    end
                end
                MS_RD_SRC: begin
                    mem_wr_data <= cr_rd_data.gt;
                    mem_wr_en   <= 1'b1;
                    tmo_cnt     <= TW'(MEM_TIMEOUT - 1);
                    state       <= MS_WRITE;
                end
                MS_WRITE: begin
                    if (mem_wr_ack) begin
                        mem_wr_en  <= 1'b0;
                        sub_done   <= 1'b1;
                        g_bit_set  <= 1'b1;
                        g_bit_addr <= mem_addr;
                        state      <= MS_DONE;
                    end else if (tmo_cnt == '0) begin
                        mem_wr_en      <= 1'b0;
                        sub_fault      <= 1'b1;
                        sub_fault_type <= FAULT_MEM_TIMEOUT;
                        state          <= MS_FAULT;
                    end else begin
                        tmo_cnt <= tmo_cnt - 1'b1;
                    end
                end
                MS_DONE, MS_FAULT: begin
                    sub_busy <= 1'b0;
                    state    <= MS_IDLE;
                end
                default: state <= MS_IDLE;
            endcase
        end
    end

endmodule
